// File: rtl/calc_pkg.sv
// Shared types and constants for the OUT-port serial transmitter.
package calc_pkg;

    localparam int WORD_W = 16;
    localparam int BYTE_W = 8;

    localparam logic LINE_IDLE = 1'b1;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/calc_out_tx_if.sv
// Core-to-transmitter OUT handshake: value plus valid/ready.
interface calc_out_tx_if;
    import calc_pkg::*;

    logic              out_valid;
    logic [WORD_W-1:0] out_data;
    logic              out_ready;

    modport master (output out_valid, output out_data, input out_ready);
    modport slave  (input out_valid, input out_data, output out_ready);

endinterface

// File: rtl/calc_out_fifo.sv
// Synchronous word FIFO with combinational head; pointers wrap modulo DEPTH.
module calc_out_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    // Full is judged on the registered count, so a same-cycle pop never frees a slot.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rptr_q];
    assign count   = count_q;

    always_comb begin
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push) begin
            mem_d[wptr_q] = wdata;
            wptr_d        = wptr_q + 1'b1;
        end
        if (do_pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/calc_out_tx.sv
// OUT-port transmitter: buffers 16-bit words and sends each as two 8N1 frames, high byte first.
module calc_out_tx
    import calc_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int DEPTH        = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    calc_out_tx_if.slave           out_if,
    output logic                   txd,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] count
);

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    tx_state_e         state_q, state_d;
    logic [15:0]       baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic              hi_q, hi_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic              txd_q, txd_d;
    logic              busy_q, busy_d;

    logic              pop;
    logic [WORD_W-1:0] head;
    logic              fifo_full, fifo_empty;
    logic [BYTE_W-1:0] cur_byte;
    logic              baud_last;

    calc_out_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WORD_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (out_if.out_valid),
        .pop   (pop),
        .wdata (out_if.out_data),
        .rdata (head),
        .count (count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign out_if.out_ready = !fifo_full;
    assign cur_byte  = hi_q ? word_q[WORD_W-1:BYTE_W] : word_q[BYTE_W-1:0];
    assign baud_last = (baud_q == BAUD_LAST);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        hi_d    = hi_q;
        word_d  = word_q;
        pop     = 1'b0;
        case (state_q)
            TX_IDLE: begin
                baud_d = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    word_d  = head;
                    hi_d    = 1'b1;
                    state_d = TX_START;
                end
            end
            TX_START: begin
                if (baud_last) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = TX_DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            TX_DATA: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = TX_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            TX_STOP: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (hi_q) begin
                        hi_d    = 1'b0;
                        state_d = TX_START;
                    end else begin
                        state_d = TX_IDLE;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    // Line level follows the state one cycle later, keeping txd a clean flop output.
    always_comb begin
        txd_d = LINE_IDLE;
        case (state_q)
            TX_START: txd_d = 1'b0;
            TX_DATA:  txd_d = cur_byte[bit_q];
            default:  txd_d = LINE_IDLE;
        endcase
        busy_d = (state_q != TX_IDLE) || !fifo_empty;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= TX_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            hi_q    <= 1'b1;
            word_q  <= '0;
            txd_q   <= LINE_IDLE;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            hi_q    <= hi_d;
            word_q  <= word_d;
            txd_q   <= txd_d;
            busy_q  <= busy_d;
        end
    end

    assign txd  = txd_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_calc_out_tx.sv
// Self-checking bench for calc_out_tx against a word/frame level reference model.
module tb_calc_out_tx;
    import calc_pkg::*;

    localparam int CPB      = 4;
    localparam int DEPTH    = 4;
    localparam int CW       = $clog2(DEPTH) + 1;
    localparam int WORD_CYC = 20 * CPB;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          txd;
    logic          busy;
    logic [CW-1:0] count;

    calc_out_tx_if out_if ();

    calc_out_tx #(
        .CLKS_PER_BIT (CPB),
        .DEPTH        (DEPTH)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .out_if (out_if),
        .txd    (txd),
        .busy   (busy),
        .count  (count)
    );

    always #5 clk = ~clk;

    int unsigned total = 0;
    int unsigned bad   = 0;

    // Reference model: queued words, expected line samples, remaining frame time.
    logic [15:0] m_fifo [$];
    bit          m_line [$];
    int          m_tx  = 0;
    bit          m_acc = 1'b0;

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_fifo.delete();
        m_line.delete();
        m_tx = 0;
    endtask

    // 8N1 frames, high byte first, LSB first within a byte.
    task automatic add_frame(input logic [15:0] w);
        logic [7:0] b;
        bit         v;
        for (int hb = 0; hb < 2; hb++) begin
            b = (hb == 0) ? w[15:8] : w[7:0];
            for (int s = 0; s < 10; s++) begin
                if (s == 0)      v = 1'b0;
                else if (s == 9) v = 1'b1;
                else             v = b[s-1];
                repeat (CPB) m_line.push_back(v);
            end
        end
    endtask

    function automatic bit model_idle();
        return (m_fifo.size() == 0) && (m_tx == 0) && (m_line.size() == 0);
    endfunction

    task automatic tick();
        bit          exp_txd;
        bit          exp_busy;
        bit          push_ok;
        bit          pop_ok;
        logic [15:0] w;
        @(posedge clk);
        m_acc = 1'b0;
        if (!rst_n) begin
            model_reset();
            exp_txd  = 1'b1;
            exp_busy = 1'b0;
        end else begin
            exp_busy = (m_tx > 0) || (m_fifo.size() > 0);
            push_ok  = out_if.out_valid && (m_fifo.size() != DEPTH);
            pop_ok   = 1'b0;
            if (m_tx > 0) m_tx--;
            else if (m_fifo.size() > 0) pop_ok = 1'b1;
            exp_txd = (m_line.size() > 0) ? m_line.pop_front() : 1'b1;
            if (pop_ok) begin
                w = m_fifo.pop_front();
                add_frame(w);
                m_tx = WORD_CYC;
            end
            if (push_ok) begin
                m_fifo.push_back(out_if.out_data);
                m_acc = 1'b1;
            end
        end
        #1;
        check_eq("txd", txd, exp_txd);
        check_eq("count", count, m_fifo.size());
        check_eq("out_ready", out_if.out_ready, m_fifo.size() != DEPTH);
        check_eq("busy", busy, exp_busy);
    endtask

    task automatic send(input logic [15:0] w);
        out_if.out_valid = 1'b1;
        out_if.out_data  = w;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (m_acc) break;
        end
        check_eq("push_accepted", m_acc, 1);
        out_if.out_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 3000; i++) begin
            if (model_idle()) break;
            tick();
        end
        check_eq("drain_done", model_idle(), 1);
        repeat (5) tick();
    endtask

    int lat;
    int gap;

    initial begin
        out_if.out_valid = 1'b0;
        out_if.out_data  = '0;
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (50) tick();

        // Single word: start bit appears two edges after the push edge.
        send(16'hA5C3);
        lat = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            lat++;
            if (txd == 1'b0) break;
        end
        check_eq("latency", lat, 2);
        drain();

        // Fill past capacity: the last word waits for a pop while the FIFO is full.
        for (int i = 1; i <= 6; i++) send(16'(i));
        drain();

        // Back-to-back words.
        send(16'h1234);
        send(16'h5678);
        drain();

        // Reset during the DATA state of the high byte 0x00, with a second word queued.
        send(16'h00FF);
        send(16'h1111);
        repeat (10) tick();
        check_eq("pre_reset_txd", txd, 0);
        rst_n = 1'b0;
        #1;
        check_eq("rst_txd", txd, 1);
        check_eq("rst_count", count, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_ready", out_if.out_ready, 1);
        model_reset();
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (40) tick();

        // Randomized words with random gaps, including bursts that hit full.
        for (int n = 0; n < 30; n++) begin
            gap = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 100));
            repeat (gap) tick();
            send(16'($urandom));
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
